// File: rtl/hdmi_tx_pkg.sv
// Shared definitions for the HDMI/DVI TMDS transmit encoder: mode encodings,
// fixed symbol codes (stored with bit 0 = first transmitted bit), TERC4 table.
package hdmi_tx_pkg;

    typedef logic [9:0] symbol_t;

    localparam logic [2:0] MODE_CONTROL      = 3'd0;
    localparam logic [2:0] MODE_VIDEO        = 3'd1;
    localparam logic [2:0] MODE_VIDEO_GUARD  = 3'd2;
    localparam logic [2:0] MODE_ISLAND       = 3'd3;
    localparam logic [2:0] MODE_ISLAND_GUARD = 3'd4;

    // Codes are written below in transmit order (leftmost char first); this flips them into bit order.
    function automatic symbol_t tx_order(input logic [9:0] s);
        symbol_t r;
        for (int unsigned i = 0; i < 10; i++) r[i] = s[9-i];
        return r;
    endfunction

    localparam symbol_t CTRL_CODE_00 = tx_order(10'b0010101011);
    localparam symbol_t CTRL_CODE_01 = tx_order(10'b1101010100);
    localparam symbol_t CTRL_CODE_10 = tx_order(10'b0010101010);
    localparam symbol_t CTRL_CODE_11 = tx_order(10'b1101010101);

    localparam symbol_t GUARD_CODE_A = tx_order(10'b1011001100);
    localparam symbol_t GUARD_CODE_B = tx_order(10'b0100110011);

    function automatic symbol_t ctrl_code(input logic [1:0] c);
        case (c)
            2'b00:   return CTRL_CODE_00;
            2'b01:   return CTRL_CODE_01;
            2'b10:   return CTRL_CODE_10;
            default: return CTRL_CODE_11;
        endcase
    endfunction

    function automatic symbol_t terc4_code(input logic [3:0] n);
        case (n)
            4'h0:    return tx_order(10'b1010011100);
            4'h1:    return tx_order(10'b1001100011);
            4'h2:    return tx_order(10'b1011100100);
            4'h3:    return tx_order(10'b1011100010);
            4'h4:    return tx_order(10'b0101110001);
            4'h5:    return tx_order(10'b0100011110);
            4'h6:    return tx_order(10'b0110001110);
            4'h7:    return tx_order(10'b0100111100);
            4'h8:    return tx_order(10'b1011001100);
            4'h9:    return tx_order(10'b0100111001);
            4'hA:    return tx_order(10'b0110011100);
            4'hB:    return tx_order(10'b1011000110);
            4'hC:    return tx_order(10'b1010001110);
            4'hD:    return tx_order(10'b1001110001);
            4'hE:    return tx_order(10'b0101100011);
            default: return tx_order(10'b1011000011);
        endcase
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) r = r + {3'b000, v[i]};
        return r;
    endfunction

endpackage

// File: rtl/hdmi_tx_encode_lane.sv
// Single TMDS lane: 3-stage pipeline (q_m / disparity / output) plus running cnt.
// Data-island support is built only when HDMI_TX_ENCODE_TERC4_EN is defined.
module hdmi_tx_encode_lane
    import hdmi_tx_pkg::*;
#(
    parameter int unsigned LANE_PAT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cke,
    input  logic [2:0] mode,
    input  logic [7:0] d,
    input  logic [1:0] c,
    input  logic [3:0] aux,
    output logic [9:0] sym
);

    logic [3:0]        n1;
    logic              use_xnor;
    logic [8:0]        qm;
    logic [2:0]        mode_n;

    logic [8:0]        s1_qm;
    logic [2:0]        s1_mode;
    logic [1:0]        s1_c;
    logic signed [5:0] s1_diff_wide;

    logic [8:0]        s2_qm;
    logic [2:0]        s2_mode;
    logic [1:0]        s2_c;
    logic signed [4:0] s2_diff;

    logic signed [4:0] cnt;
    logic signed [4:0] cnt_next;
    logic signed [5:0] cnt_ext;
    logic signed [5:0] diff_ext;
    logic signed [5:0] cnt_sum;
    symbol_t           video_sym;
    symbol_t           sym_next;

    always_comb begin
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
        qm       = '0;
        qm[0]    = d[0];
        for (int unsigned i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8]    = ~use_xnor;
    end

    always_comb begin
        case (mode)
            MODE_VIDEO, MODE_VIDEO_GUARD:   mode_n = mode;
`ifdef HDMI_TX_ENCODE_TERC4_EN
            MODE_ISLAND, MODE_ISLAND_GUARD: mode_n = mode;
`endif
            default:                        mode_n = MODE_CONTROL;
        endcase
    end

    // diff spans -8..+8, so it is held in 5 bits rather than 4
    assign s1_diff_wide = $signed({1'b0, popcount8(s1_qm[7:0]), 1'b0}) - 6'sd8;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_qm   <= '0;
            s1_mode <= MODE_CONTROL;
            s1_c    <= '0;
            s2_qm   <= '0;
            s2_mode <= MODE_CONTROL;
            s2_c    <= '0;
            s2_diff <= '0;
        end else if (cke) begin
            s1_qm   <= qm;
            s1_mode <= mode_n;
            s1_c    <= c;
            s2_qm   <= s1_qm;
            s2_mode <= s1_mode;
            s2_c    <= s1_c;
            s2_diff <= s1_diff_wide[4:0];
        end
    end

`ifdef HDMI_TX_ENCODE_TERC4_EN
    logic [3:0] s1_aux;
    logic [3:0] s2_aux;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_aux <= '0;
            s2_aux <= '0;
        end else if (cke) begin
            s1_aux <= aux;
            s2_aux <= s1_aux;
        end
    end
`else
    logic unused_aux;
    assign unused_aux = ^aux;
`endif

    assign cnt_ext  = {cnt[4], cnt};
    assign diff_ext = {s2_diff[4], s2_diff};

    always_comb begin
        video_sym = '0;
        cnt_sum   = '0;
        if (cnt == 5'sd0 || s2_diff == 5'sd0) begin
            video_sym = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
            cnt_sum   = s2_qm[8] ? cnt_ext + diff_ext : cnt_ext - diff_ext;
        end else if (cnt[4] == s2_diff[4]) begin
            video_sym = {1'b1, s2_qm[8], ~s2_qm[7:0]};
            cnt_sum   = cnt_ext + (s2_qm[8] ? 6'sd2 : 6'sd0) - diff_ext;
        end else begin
            video_sym = {1'b0, s2_qm[8], s2_qm[7:0]};
            cnt_sum   = cnt_ext + diff_ext - (s2_qm[8] ? 6'sd0 : 6'sd2);
        end
    end

    always_comb begin
        sym_next = ctrl_code(s2_c);
        cnt_next = '0;
        case (s2_mode)
            MODE_VIDEO: begin
                sym_next = video_sym;
                cnt_next = cnt_sum[4:0];
            end
            MODE_VIDEO_GUARD:  sym_next = (LANE_PAT == 1) ? GUARD_CODE_B : GUARD_CODE_A;
`ifdef HDMI_TX_ENCODE_TERC4_EN
            MODE_ISLAND:       sym_next = terc4_code(s2_aux);
            MODE_ISLAND_GUARD: sym_next = (LANE_PAT == 0) ? terc4_code({2'b11, s2_c}) : GUARD_CODE_B;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym <= CTRL_CODE_00;
            cnt <= '0;
        end else if (cke) begin
            sym <= sym_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/hdmi_tx_encode.sv
// Multi-lane TMDS encoder top: CHANNELS lanes sharing mode and cke.
// Define HDMI_TX_ENCODE_TERC4_EN to enable data-island (TERC4) periods.
module hdmi_tx_encode
    import hdmi_tx_pkg::*;
#(
    parameter int unsigned CHANNELS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,
    input  logic [2:0]            in_mode,
    input  logic [8*CHANNELS-1:0] in_d,
    input  logic [2*CHANNELS-1:0] in_c,
    input  logic [4*CHANNELS-1:0] in_aux,
    output logic [10*CHANNELS-1:0] out_d
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        hdmi_tx_encode_lane #(
            .LANE_PAT(i % 3)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .cke  (cke),
            .mode (in_mode),
            .d    (in_d[8*i +: 8]),
            .c    (in_c[2*i +: 2]),
            .aux  (in_aux[4*i +: 4]),
            .sym  (out_d[10*i +: 10])
        );
    end

endmodule

// File: tb/tb_hdmi_tx_encode.sv
// Self-checking bench for hdmi_tx_encode (3 lanes): vector table, directed
// sequences and a random run against a transmit-order string model.
module tb_hdmi_tx_encode;

    localparam int unsigned CH = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cke;
    logic [2:0]  in_mode;
    logic [23:0] in_d;
    logic [5:0]  in_c;
    logic [11:0] in_aux;
    logic [29:0] out_d;

    hdmi_tx_encode #(.CHANNELS(CH)) dut (
        .clk   (clk),
        .reset (reset),
        .cke   (cke),
        .in_mode(in_mode),
        .in_d  (in_d),
        .in_c  (in_c),
        .in_aux(in_aux),
        .out_d (out_d)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    string CTRL_S[4]   = '{"0010101011", "1101010100", "0010101010", "1101010101"};
    string GUARD_S[3]  = '{"1011001100", "0100110011", "1011001100"};
    string IGUARD_S    = "0100110011";
    string TERC4_S[16] = '{"1010011100", "1001100011", "1011100100", "1011100010",
                           "0101110001", "0100011110", "0110001110", "0100111100",
                           "1011001100", "0100111001", "0110011100", "1011000110",
                           "1010001110", "1001110001", "0101100011", "1011000011"};

    int          mcnt[CH];
    logic [29:0] exp_q[$];
    logic [29:0] cur_exp;
    logic [29:0] r3;

    typedef struct {
        logic [2:0]  mode;
        logic [23:0] d;
        logic [5:0]  c;
        logic [11:0] aux;
        string       e0;
        string       e1;
        string       e2;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [9:0] code(input string s);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = (s[i] == "1");
        return r;
    endfunction

    function automatic vec_t mk(input logic [2:0] m, input logic [23:0] d, input logic [5:0] c,
                                input logic [11:0] aux, input string e0, input string e1, input string e2);
        vec_t v;
        v.mode = m; v.d = d; v.c = c; v.aux = aux;
        v.e0 = e0; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    function automatic logic [9:0] model_lane(input int lane, input logic [2:0] m, input logic [7:0] d,
                                              input logic [1:0] c, input logic [3:0] aux);
        int         n1, ones, diff;
        logic       use_xnor;
        logic [7:0] q;
        logic       q8;
        logic [9:0] o;
        if (m != 3'd1) mcnt[lane] = 0;
        case (m)
            3'd1: begin
                n1 = 0;
                for (int i = 0; i < 8; i++) n1 += int'(d[i]);
                use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
                q[0] = d[0];
                for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
                q8 = !use_xnor;
                ones = 0;
                for (int i = 0; i < 8; i++) ones += int'(q[i]);
                diff = ones - (8 - ones);
                o[8] = q8;
                if (mcnt[lane] == 0 || diff == 0) begin
                    o[9] = !q8;
                    o[7:0] = q8 ? q : ~q;
                    mcnt[lane] += q8 ? diff : -diff;
                end else if ((mcnt[lane] > 0) == (diff > 0)) begin
                    o[9] = 1'b1;
                    o[7:0] = ~q;
                    mcnt[lane] += 2 * int'(q8) - diff;
                end else begin
                    o[9] = 1'b0;
                    o[7:0] = q;
                    mcnt[lane] += diff - 2 * int'(!q8);
                end
                return o;
            end
            3'd2: return code(GUARD_S[lane % 3]);
`ifdef HDMI_TX_ENCODE_TERC4_EN
            3'd3: return code(TERC4_S[aux]);
            3'd4: return (lane % 3 == 0) ? code(TERC4_S[{2'b11, c}]) : code(IGUARD_S);
`endif
            default: return code(CTRL_S[c]);
        endcase
    endfunction

    function automatic logic [29:0] model_all();
        logic [29:0] r;
        for (int l = 0; l < int'(CH); l++)
            r[10*l +: 10] = model_lane(l, in_mode, in_d[8*l +: 8], in_c[2*l +: 2], in_aux[4*l +: 4]);
        return r;
    endfunction

    task automatic check(input string name, input logic [29:0] act, input logic [29:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (cke) begin
            exp_q.push_back(model_all());
            cur_exp = exp_q.pop_front();
        end
        #1;
        check("model", out_d, cur_exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("reset_async", out_d, r3);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", out_d, r3);
        end
        exp_q.delete();
        exp_q.push_back(r3);
        exp_q.push_back(r3);
        cur_exp = r3;
        foreach (mcnt[l]) mcnt[l] = 0;
        reset = 1'b1;
    endtask

    task automatic set_in(input logic [2:0] m, input logic [23:0] d, input logic [5:0] c, input logic [11:0] aux);
        in_mode = m; in_d = d; in_c = c; in_aux = aux;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] frozen;
        r3 = {3{code(CTRL_S[0])}};
        reset = 1'b1;
        cke   = 1'b1;
        set_in(3'd0, '0, '0, '0);
        #2;

        // Reset and release with CONTROL 00: three edges of control code
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("release_ctrl", out_d, r3);
        end

        // VIDEO 0x00 twice from cnt 0
        set_in(3'd1, 24'h000000, '0, '0);
        tick();
        tick();
        set_in(3'd0, '0, '0, '0);
        tick();
        check("video_sym1", out_d, {3{code("0000000010")}});
        tick();
        check("video_sym2", out_d, {3{code("1111111111")}});
        tick();
        check("video_after", out_d, r3);

        // VIDEO_GUARD appears exactly 3 edges after the mode change
        repeat (3) tick();
        set_in(3'd2, '0, '0, '0);
        tick();
        check("vguard_e1", out_d, r3);
        tick();
        check("vguard_e2", out_d, r3);
        tick();
        check("vguard_e3", out_d, {code("1011001100"), code("0100110011"), code("1011001100")});

        // Non-video vector table, each held for 3 edges
        tbl[0] = mk(3'd0, 24'h123456, 6'b000000, 12'h000, "0010101011", "0010101011", "0010101011");
        tbl[1] = mk(3'd0, 24'hABCDEF, 6'b111001, 12'hFFF, "1101010100", "0010101010", "1101010101");
        tbl[2] = mk(3'd6, 24'h000000, 6'b111111, 12'h000, "1101010101", "1101010101", "1101010101");
        tbl[3] = mk(3'd2, 24'hFFFFFF, 6'b000000, 12'h000, "1011001100", "0100110011", "1011001100");
`ifdef HDMI_TX_ENCODE_TERC4_EN
        tbl[4] = mk(3'd3, 24'h000000, 6'b101010, 12'h5F0, "1010011100", "1011000011", "0100011110");
        tbl[5] = mk(3'd4, 24'h000000, 6'b000001, 12'h000, "1001110001", "0100110011", "0100110011");
        tbl[6] = mk(3'd4, 24'h000000, 6'b000010, 12'hA5C, "0101100011", "0100110011", "0100110011");
`else
        tbl[4] = mk(3'd3, 24'h000000, 6'b101010, 12'h5F0, "0010101010", "0010101010", "0010101010");
        tbl[5] = mk(3'd4, 24'h000000, 6'b000001, 12'h000, "1101010100", "0010101011", "0010101011");
        tbl[6] = mk(3'd4, 24'h000000, 6'b000010, 12'hA5C, "0010101010", "0010101011", "0010101011");
`endif
        for (int k = 0; k < 7; k++) begin
            set_in(tbl[k].mode, tbl[k].d, tbl[k].c, tbl[k].aux);
            repeat (3) tick();
            check($sformatf("table_%0d", k), out_d, {code(tbl[k].e2), code(tbl[k].e1), code(tbl[k].e0)});
        end

        // cke low for 5 cycles in the middle of a VIDEO run
        set_in(3'd1, '0, '0, '0);
        repeat (6) begin
            in_d = 24'($urandom);
            tick();
        end
        frozen = out_d;
        cke = 1'b0;
        repeat (5) begin
            in_d    = 24'($urandom);
            in_mode = 3'($urandom_range(0, 7));
            tick();
            check("stall_hold", out_d, frozen);
        end
        in_mode = 3'd1;
        cke = 1'b1;
        repeat (10) begin
            in_d = 24'($urandom);
            tick();
        end

        // Random run with occasional stalls and one mid-frame reset
        for (int k = 0; k < 400; k++) begin
            if (k == 200) do_reset();
            in_mode = ($urandom_range(0, 9) < 5) ? 3'd1 : 3'($urandom_range(0, 7));
            in_d    = 24'($urandom);
            in_c    = 6'($urandom);
            in_aux  = 12'($urandom);
            cke     = ($urandom_range(0, 7) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
